// File: rtl/rf_multiport.sv
// rtl/rf_multiport.sv - parametrised multi-port register file with dual write, bypass and busy scoreboard
module rf_multiport #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       WrEn0,
  input  logic [ADDR_W-1:0]          Awr0,
  input  logic [DATA_W-1:0]          Din0,
  input  logic                       WrEn1,
  input  logic [ADDR_W-1:0]          Awr1,
  input  logic [DATA_W-1:0]          Din1,
  input  logic [NUM_RD*ADDR_W-1:0]   Ard,
  output logic [NUM_RD*DATA_W-1:0]   Dout,
  input  logic                       RsvEn,
  input  logic [ADDR_W-1:0]          Arsv,
  output logic [NUM_RD-1:0]          Busy
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_next;
  logic              wr0_ok;
  logic              wr1_ok;
  logic              rsv_ok;

  // Register 0 is hardwired when ZERO_REG is set, so it never accepts data or reservations.
  assign wr0_ok = WrEn0 && !((ZERO_REG != 0) && (Awr0 == '0));
  assign wr1_ok = WrEn1 && !((ZERO_REG != 0) && (Awr1 == '0));
  assign rsv_ok = RsvEn && !((ZERO_REG != 0) && (Arsv == '0));

  // A reservation is applied last so a new producer wins over a completing one.
  always_comb begin
    busy_next = busy_q;
    if (wr0_ok) busy_next[Awr0] = 1'b0;
    if (wr1_ok) busy_next[Awr1] = 1'b0;
    if (rsv_ok) busy_next[Arsv] = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      busy_q <= '0;
    end else begin
      if (wr0_ok) regs[Awr0] <= Din0;
      if (wr1_ok) regs[Awr1] <= Din1;
      busy_q <= busy_next;
    end
  end

  genvar k;
  generate
    for (k = 0; k < NUM_RD; k++) begin : g_rd
      logic [ADDR_W-1:0] rd_a;
      logic [DATA_W-1:0] rd_v;

      assign rd_a = Ard[k*ADDR_W +: ADDR_W];

      // Port 1 is checked first so same-address dual writes bypass the value that will be stored.
      always_comb begin
        rd_v = regs[rd_a];
        if ((BYPASS != 0) && !RST) begin
          if (WrEn1 && (Awr1 == rd_a))      rd_v = Din1;
          else if (WrEn0 && (Awr0 == rd_a)) rd_v = Din0;
        end
        if ((ZERO_REG != 0) && (rd_a == '0)) rd_v = '0;
      end

      assign Dout[k*DATA_W +: DATA_W] = rd_v;
      assign Busy[k] = busy_q[rd_a];
    end
  endgenerate

endmodule
